// File: rtl/cpu_in_conditioner.sv
// Input front end: 2-flop synchroniser, shared sample prescaler and per-channel
// debounce producing clean levels plus registered one-cycle rise/fall strobes.
module cpu_in_conditioner #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SAMPLE_DIV      = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             tick_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PC_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PC_W-1:0]  PC_MAX  = PC_W'(SAMPLE_DIV - 1);

  logic [WIDTH-1:0] s1_reg;
  logic [WIDTH-1:0] s2_reg;
  logic [PC_W-1:0]  pc_reg;
  logic [PC_W-1:0]  pc_next;
  logic             tick;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_reg <= '0;
      s2_reg <= '0;
      pc_reg <= '0;
    end else begin
      s1_reg <= in_i;
      s2_reg <= s1_reg;
      pc_reg <= pc_next;
    end
  end

  assign tick = (pc_reg == PC_MAX);

  always_comb begin
    pc_next = pc_reg + PC_W'(1);
    if (tick) begin
      pc_next = '0;
    end
  end

  // With SAMPLE_DIV=1 the tick is permanently true, so mask it while in reset.
  assign tick_o = tick & ~rst_i;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             level_reg;
      logic             level_next;
      logic             rise_reg;
      logic             rise_next;
      logic             fall_reg;
      logic             fall_next;

      always_comb begin
        cnt_next   = cnt_reg;
        level_next = level_reg;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        if (s2_reg[gi] == level_reg) begin
          cnt_next = '0;
        end else if (tick) begin
          if (cnt_reg == CNT_MAX) begin
            level_next = s2_reg[gi];
            cnt_next   = '0;
            rise_next  = s2_reg[gi];
            fall_next  = ~s2_reg[gi];
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          cnt_reg   <= '0;
          level_reg <= 1'b0;
          rise_reg  <= 1'b0;
          fall_reg  <= 1'b0;
        end else begin
          cnt_reg   <= cnt_next;
          level_reg <= level_next;
          rise_reg  <= rise_next;
          fall_reg  <= fall_next;
        end
      end

      assign level_o[gi] = level_reg;
      assign rise_o[gi]  = rise_reg;
      assign fall_o[gi]  = fall_reg;
    end
  endgenerate

endmodule

// File: tb/tb_cpu_in_conditioner.sv
// Bench for cpu_in_conditioner: a fast (SAMPLE_DIV=1) and a slow (SAMPLE_DIV=4)
// instance share stimulus; an edge-indexed model is compared every cycle.
module tb_cpu_in_conditioner;
  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_v;
  logic [W-1:0] lvl1, rise1, fall1;
  logic [W-1:0] lvl4, rise4, fall4;
  logic         tick1, tick4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpu_in_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .SAMPLE_DIV(1)) dut (
    .clk_i(clk), .rst_i(rst), .in_i(in_v),
    .level_o(lvl1), .rise_o(rise1), .fall_o(fall1), .tick_o(tick1)
  );

  cpu_in_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .SAMPLE_DIV(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .in_i(in_v),
    .level_o(lvl4), .rise_o(rise4), .fall_o(fall4), .tick_o(tick4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sd_of(input int c);
    return (c == 0) ? 1 : 4;
  endfunction

  // Model: k counts edges since reset release; the synchronised value used at
  // edge k is the input sampled at edge k-2; ticks fall on edges with k%SD==0.
  // A channel flips once D ticks have elapsed since the last edge at which the
  // synchronised value agreed with the level.
  int           m_k;
  logic [W-1:0] m_s1, m_s2;
  logic [W-1:0] m_level [2];
  logic [W-1:0] m_rise  [2];
  logic [W-1:0] m_fall  [2];
  int           m_la    [2][W];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k  <= 0;
      m_s1 <= '0;
      m_s2 <= '0;
      for (int c = 0; c < 2; c++) begin
        m_level[c] <= '0;
        m_rise[c]  <= '0;
        m_fall[c]  <= '0;
        for (int ch = 0; ch < W; ch++) m_la[c][ch] <= 0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        for (int ch = 0; ch < W; ch++) begin
          m_rise[c][ch] <= 1'b0;
          m_fall[c][ch] <= 1'b0;
          if (m_s2[ch] == m_level[c][ch]) begin
            m_la[c][ch] <= m_k + 1;
          end else if ((m_k + 1) / sd_of(c) - m_la[c][ch] / sd_of(c) == D) begin
            m_level[c][ch] <= m_s2[ch];
            m_rise[c][ch]  <= m_s2[ch];
            m_fall[c][ch]  <= ~m_s2[ch];
            m_la[c][ch]    <= m_k + 1;
          end
        end
      end
      m_k  <= m_k + 1;
      m_s2 <= m_s1;
      m_s1 <= in_v;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_level1", 32'(lvl1), 0);
      chk("rst_rise1", 32'(rise1), 0);
      chk("rst_fall1", 32'(fall1), 0);
      chk("rst_tick1", 32'(tick1), 0);
      chk("rst_level4", 32'(lvl4), 0);
      chk("rst_tick4", 32'(tick4), 0);
    end else begin
      chk("cmp_level1", 32'(lvl1), 32'(m_level[0]));
      chk("cmp_rise1", 32'(rise1), 32'(m_rise[0]));
      chk("cmp_fall1", 32'(fall1), 32'(m_fall[0]));
      chk("cmp_tick1", 32'(tick1), 1);
      chk("cmp_level4", 32'(lvl4), 32'(m_level[1]));
      chk("cmp_rise4", 32'(rise4), 32'(m_rise[1]));
      chk("cmp_fall4", 32'(fall4), 32'(m_fall[1]));
      chk("cmp_tick4", 32'(tick4), 32'((m_k % 4) == 3));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Edges until the selected strobe is seen (0=rise1, 1=fall1, 2=rise4); -1 on timeout.
  task automatic wait_strobe(input int sel, input int ch, output int n);
    logic hit;
    n = -1;
    for (int e = 1; e <= 40; e++) begin
      cyc();
      case (sel)
        0:       hit = rise1[ch];
        1:       hit = fall1[ch];
        default: hit = rise4[ch];
      endcase
      if (hit) begin
        n = e;
        break;
      end
    end
  endtask

  initial begin
    int n, rises, falls, edge_at, first_tick;
    rst  = 1'b1;
    in_v = 8'hFF;
    repeat (3) cyc();
    chk("reset_level", 32'(lvl1), 0);
    chk("reset_rise", 32'(rise1), 0);
    chk("reset_tick", 32'(tick1), 0);

    // Power-up: all inputs high at release.
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      cyc();
      if (e < 6) chk("pwrup_level_early", 32'(lvl1), 0);
      if (e == 6) begin
        chk("pwrup_level", 32'(lvl1), 32'hFF);
        chk("pwrup_rise", 32'(rise1), 32'hFF);
      end
      if (e == 7) begin
        chk("pwrup_rise_once", 32'(rise1), 0);
        chk("pwrup_level_hold", 32'(lvl1), 32'hFF);
      end
    end
    in_v = 8'h00;
    repeat (30) cyc();

    // Clean step up and down on channel 0.
    in_v[0] = 1'b1;
    wait_strobe(0, 0, n);
    chk("step_rise_latency", n, 6);
    cyc();
    chk("step_rise_single", 32'(rise1[0]), 0);
    repeat (20) cyc();
    in_v[0] = 1'b0;
    wait_strobe(1, 0, n);
    chk("step_fall_latency", n, 6);
    cyc();
    chk("step_fall_single", 32'(fall1[0]), 0);
    repeat (30) cyc();

    // Glitches on channel 1: 3 cycles rejected, 4 cycles accepted.
    for (int len = 3; len <= 4; len++) begin
      rises   = 0;
      edge_at = -1;
      in_v[1] = 1'b1;
      for (int e = 1; e <= 15; e++) begin
        cyc();
        if (e == len) in_v[1] = 1'b0;
        if (rise1[1]) begin
          rises++;
          edge_at = e;
        end
      end
      if (len == 3) begin
        chk("glitch3_rises", rises, 0);
        chk("glitch3_level", 32'(lvl1[1]), 0);
      end else begin
        chk("glitch4_rises", rises, 1);
        chk("glitch4_edge", edge_at, 6);
      end
      repeat (30) cyc();
    end

    // Bounce on channel 2 then a stable high.
    rises = 0;
    falls = 0;
    edge_at = -1;
    for (int t = 0; t < 6; t++) begin
      in_v[2] = (t % 2 == 0);
      repeat (2) begin
        cyc();
        if (rise1[2]) rises++;
        if (fall1[2]) falls++;
      end
    end
    in_v[2] = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      cyc();
      if (rise1[2]) begin
        rises++;
        edge_at = e;
      end
      if (fall1[2]) falls++;
    end
    chk("bounce_rises", rises, 1);
    chk("bounce_falls", falls, 0);
    chk("bounce_edge", edge_at, 6);
    in_v[2] = 1'b0;
    repeat (30) cyc();

    // Prescaled instance: tick period and step latency window.
    first_tick = -1;
    for (int e = 0; e < 8; e++) begin
      if (tick4) begin
        first_tick = e;
        break;
      end
      cyc();
    end
    chk("div4_tick_found", 32'(first_tick >= 0), 1);
    for (int j = 1; j <= 8; j++) begin
      cyc();
      chk("div4_tick_period", 32'(tick4), 32'(j % 4 == 0));
    end
    in_v[4] = 1'b1;
    wait_strobe(2, 4, n);
    chk("div4_step_window", 32'(n >= 15 && n <= 18), 1);
    repeat (30) cyc();
    in_v[4] = 1'b0;
    repeat (30) cyc();

    // 10-cycle glitch on channel 5 must not reach the prescaled instance.
    rises   = 0;
    in_v[5] = 1'b1;
    in_v[6] = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      cyc();
      if (e == 10) in_v[5] = 1'b0;
      if (rise4[5]) rises++;
    end
    chk("div4_glitch_rises", rises, 0);
    chk("div4_glitch_level", 32'(lvl4[5]), 0);

    // Reset in the middle of a count on channel 3.
    in_v[3] = 1'b1;
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    chk("midreset_level_cleared", 32'(lvl1), 0);
    chk("midreset_level4_cleared", 32'(lvl4), 0);
    cyc();
    rst = 1'b0;
    wait_strobe(0, 3, n);
    chk("midreset_rise_latency", n, 6);

    repeat (5) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
